// File: rtl/pe_feeder_if.sv
// pe_feeder_if: 16-bit valid/ready word stream.
// The master drives valid/data, the slave drives ready.
interface pe_feeder_if;
    logic        valid;
    logic        ready;
    logic [15:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pe_feeder.sv
// pe_feeder: load/drain stage for one row-stationary PE.
// Builds filter/ifmap/psum vectors from a word stream, fires the PE, drains its psums.
module pe_feeder #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    pe_feeder_if.slave  in_if,
    input  logic        filt_keep,
    output logic [15:0] FILTER_OUT [0:2],
    output logic [15:0] DATA_OUT [0:6],
    output logic [15:0] PSUM_OUT [0:4],
    output logic        PE_EN,
    input  logic        PE_DONE,
    input  logic [15:0] PE_PSUM [0:4],
    pe_feeder_if.master out_if,
    output logic        busy,
    output logic        err
);
    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_FIRE  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [2:0]    idx;
    logic [TW-1:0] tcnt;
    logic [15:0]   result [0:4];
    logic [3:0]    doff;
    logic [3:0]    poff;
    logic          in_fire;
    logic          out_fire;

    // Handshake outputs are gated by rst so nothing is offered on a reset cycle.
    assign in_if.ready  = (state == S_LOAD) && !rst;
    assign in_fire      = in_if.valid && in_if.ready;
    assign out_if.valid = (state == S_DRAIN) && !rst;
    assign out_fire     = out_if.valid && out_if.ready;
    assign out_if.data  = (state == S_DRAIN) ? result[idx] : '0;
    assign PE_EN        = (state == S_FIRE) && !rst;
    assign busy         = (state != S_LOAD) || (cnt != 4'd0);
    assign doff         = cnt - 4'd3;
    assign poff         = cnt - 4'd10;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOAD;
            cnt   <= '0;
            idx   <= '0;
            tcnt  <= '0;
            err   <= 1'b0;
            for (int i = 0; i < 3; i++) FILTER_OUT[i] <= '0;
            for (int i = 0; i < 7; i++) DATA_OUT[i] <= '0;
            for (int i = 0; i < 5; i++) PSUM_OUT[i] <= '0;
            for (int i = 0; i < 5; i++) result[i] <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (in_fire) begin
                        // filt_keep only matters on the first word of a group
                        if (cnt == 4'd0 && filt_keep) begin
                            DATA_OUT[0] <= in_if.data;
                            cnt         <= 4'd4;
                        end else begin
                            if (cnt < 4'd3)
                                FILTER_OUT[cnt[1:0]] <= in_if.data;
                            else if (cnt < 4'd10)
                                DATA_OUT[doff[2:0]] <= in_if.data;
                            else
                                PSUM_OUT[poff[2:0]] <= in_if.data;
                            if (cnt == 4'd14) begin
                                cnt   <= '0;
                                state <= S_FIRE;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    end
                end
                S_FIRE: begin
                    tcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (PE_DONE) begin
                        for (int i = 0; i < 5; i++) result[i] <= PE_PSUM[i];
                        idx   <= '0;
                        state <= S_DRAIN;
                    end else if (tcnt == T_LAST) begin
                        err   <= 1'b1;
                        state <= S_LOAD;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        if (idx == 3'd4) begin
                            idx   <= '0;
                            state <= S_LOAD;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: randomized scoreboard bench for pe_feeder.
// Expected psums come from a convolution reference model; a monitor checks the drain.
module tb_pe_feeder;
    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        filt_keep;
    logic [15:0] FILTER_OUT [0:2];
    logic [15:0] DATA_OUT [0:6];
    logic [15:0] PSUM_OUT [0:4];
    logic        PE_EN;
    logic        PE_DONE;
    logic [15:0] PE_PSUM [0:4];
    logic        busy;
    logic        err;

    pe_feeder_if in_bus();
    pe_feeder_if out_bus();

    pe_feeder #(.TIMEOUT(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_if     (in_bus),
        .filt_keep (filt_keep),
        .FILTER_OUT(FILTER_OUT),
        .DATA_OUT  (DATA_OUT),
        .PSUM_OUT  (PSUM_OUT),
        .PE_EN     (PE_EN),
        .PE_DONE   (PE_DONE),
        .PE_PSUM   (PE_PSUM),
        .out_if    (out_bus),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int n_pop = 0;
    int n_valid = 0;
    int n_en = 0;
    bit err_exp = 1'b0;

    logic [15:0] exp_q [$];
    logic [15:0] ref_filt [0:2];
    logic [15:0] g_f [0:2];
    logic [15:0] g_d [0:6];
    logic [15:0] g_p [0:4];

    function automatic void check(string name, logic [127:0] act, logic [127:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endfunction

    // Scoreboard monitor: every drain handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst && out_bus.valid) n_valid++;
        if (!rst && PE_EN) n_en++;
        if (!rst && out_bus.valid && out_bus.ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL out_unexpected: got %0h with empty queue", out_bus.data);
            end else begin
                check("out_data", out_bus.data, exp_q.pop_front());
            end
            n_pop++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_bus.valid = 1'b0;
        out_bus.ready = 1'b0;
        PE_DONE = 1'b0;
        filt_keep = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_bus.ready, 0);
        check("rst_pe_en", PE_EN, 0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int j = 0; j < 3; j++) ref_filt[j] = '0;
        err_exp = 1'b0;
        @(negedge clk);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_bus.valid, 0);
        check("rst_out_data", out_bus.data, 0);
        check("rst_pe_en_after", PE_EN, 0);
        check("rst_in_ready_after", in_bus.ready, 1);
        check("rst_filter", {FILTER_OUT[0], FILTER_OUT[1], FILTER_OUT[2]}, 0);
        check("rst_data", {DATA_OUT[0], DATA_OUT[1], DATA_OUT[2], DATA_OUT[3],
                           DATA_OUT[4], DATA_OUT[5], DATA_OUT[6]}, 0);
        check("rst_psum", {PSUM_OUT[0], PSUM_OUT[1], PSUM_OUT[2],
                           PSUM_OUT[3], PSUM_OUT[4]}, 0);
        tick();
    endtask

    // mode: 0 normal, 1 hold at idx 2, 2 reset at idx 3, 3 reset at word 8, 4 dead PE
    task automatic send_group(input bit keep, input bit in_stall, input int mode);
        logic [15:0] words [$];
        logic [15:0] expv [0:4];
        logic [15:0] res [0:4];
        logic [15:0] acc;
        int w, guard, pop0, en0, v0, hold, r;
        bit last_hs;
        if (!keep) for (int j = 0; j < 3; j++) ref_filt[j] = g_f[j];
        for (int k = 0; k < 5; k++) begin
            acc = g_p[k];
            for (int j = 0; j < 3; j++) acc = acc + 16'(ref_filt[j] * g_d[k + j]);
            expv[k] = acc;
        end
        if (mode != 3 && mode != 4)
            for (int k = 0; k < 5; k++) exp_q.push_back(expv[k]);
        if (!keep) for (int j = 0; j < 3; j++) words.push_back(g_f[j]);
        for (int j = 0; j < 7; j++) words.push_back(g_d[j]);
        for (int j = 0; j < 5; j++) words.push_back(g_p[j]);
        en0 = n_en;
        pop0 = n_pop;
        v0 = n_valid;
        w = 0;
        guard = 0;
        while (w < words.size() && guard < 400) begin
            guard++;
            if (in_stall && $urandom_range(0, 2) == 0) begin
                in_bus.valid = 1'b0;
            end else begin
                in_bus.valid = 1'b1;
                in_bus.data = words[w];
            end
            filt_keep = (w == 0) ? keep : 1'($urandom_range(0, 1));
            if (mode == 3 && w == 8) begin
                do_reset();
                return;
            end
            @(negedge clk);
            if (in_bus.valid && in_bus.ready) w++;
            tick();
        end
        in_bus.valid = 1'b0;
        filt_keep = 1'b0;
        check("words_accepted", w, words.size());
        @(negedge clk);
        check("pe_en_timing", PE_EN, 1);
        check("filter_vec", {FILTER_OUT[0], FILTER_OUT[1], FILTER_OUT[2]},
              {ref_filt[0], ref_filt[1], ref_filt[2]});
        check("data_vec", {DATA_OUT[0], DATA_OUT[1], DATA_OUT[2], DATA_OUT[3],
                           DATA_OUT[4], DATA_OUT[5], DATA_OUT[6]},
              {g_d[0], g_d[1], g_d[2], g_d[3], g_d[4], g_d[5], g_d[6]});
        check("psum_vec", {PSUM_OUT[0], PSUM_OUT[1], PSUM_OUT[2], PSUM_OUT[3], PSUM_OUT[4]},
              {g_p[0], g_p[1], g_p[2], g_p[3], g_p[4]});
        // PE model: 1-D row convolution on whatever vectors the feeder presents
        for (int k = 0; k < 5; k++) begin
            acc = PSUM_OUT[k];
            for (int j = 0; j < 3; j++) acc = acc + 16'(FILTER_OUT[j] * DATA_OUT[k + j]);
            res[k] = acc;
        end
        if (mode == 4) begin
            for (int c = 1; c <= T + 1; c++) begin
                tick();
                @(negedge clk);
                if (c == T) begin
                    check("err_before_timeout", err, 0);
                    check("busy_in_wait", busy, 1);
                end
            end
            err_exp = 1'b1;
            check("err_at_timeout", err, 1);
            check("in_ready_after_timeout", in_bus.ready, 1);
            check("busy_after_timeout", busy, 0);
            check("timeout_no_valid", n_valid - v0, 0);
            check("timeout_pe_en_count", n_en - en0, 1);
            tick();
            return;
        end
        r = $urandom_range(0, 3);
        repeat (r) tick();
        tick();
        PE_DONE = 1'b1;
        for (int k = 0; k < 5; k++) PE_PSUM[k] = res[k];
        tick();
        PE_DONE = 1'b0;
        hold = 0;
        guard = 0;
        last_hs = 1'b0;
        while (guard < 200) begin
            guard++;
            if (mode == 2 && n_pop - pop0 == 3) begin
                do_reset();
                return;
            end
            if (mode == 1 && n_pop - pop0 == 2 && hold < 7) begin
                out_bus.ready = 1'b0;
                hold++;
            end else begin
                out_bus.ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            if (guard == 1) check("valid_after_done", out_bus.valid, 1);
            if (mode == 1 && !out_bus.ready)
                check("bp_hold_data", {out_bus.valid, out_bus.data}, {1'b1, expv[2]});
            if (in_bus.ready) break;
            last_hs = out_bus.valid && out_bus.ready;
            tick();
        end
        out_bus.ready = 1'b0;
        check("drain_done", in_bus.ready, 1);
        check("back_to_back", last_hs, 1);
        check("drain_count", n_pop - pop0, 5);
        check("pe_en_count", n_en - en0, 1);
        check("queue_empty", exp_q.size(), 0);
        check("err_flag", err, err_exp);
        tick();
    endtask

    task automatic set_basic();
        for (int j = 0; j < 3; j++) g_f[j] = 16'(j + 1);
        for (int j = 0; j < 7; j++) g_d[j] = 16'(j + 1);
        for (int j = 0; j < 5; j++) g_p[j] = '0;
    endtask

    task automatic set_random();
        for (int j = 0; j < 3; j++) g_f[j] = 16'($urandom);
        for (int j = 0; j < 7; j++) g_d[j] = 16'($urandom);
        for (int j = 0; j < 5; j++) g_p[j] = 16'($urandom);
    endtask

    task automatic stray_done();
        int v0;
        v0 = n_valid;
        PE_DONE = 1'b1;
        for (int k = 0; k < 5; k++) PE_PSUM[k] = 16'd9;
        tick();
        PE_DONE = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stray_busy", busy, 0);
            tick();
        end
        check("stray_no_valid", n_valid - v0, 0);
    endtask

    initial begin
        rst = 1'b1;
        filt_keep = 1'b0;
        in_bus.valid = 1'b0;
        in_bus.data = '0;
        out_bus.ready = 1'b0;
        PE_DONE = 1'b0;
        for (int k = 0; k < 5; k++) PE_PSUM[k] = '0;
        do_reset();

        set_basic();
        send_group(1'b0, 1'b0, 0);

        for (int j = 0; j < 7; j++) g_d[j] = 16'd1;
        for (int j = 0; j < 5; j++) g_p[j] = 16'd10;
        send_group(1'b1, 1'b0, 0);

        set_basic();
        send_group(1'b0, 1'b1, 1);

        stray_done();
        set_random();
        send_group(1'b0, 1'b1, 0);

        set_random();
        send_group(1'b0, 1'b0, 4);

        set_random();
        send_group(1'b0, 1'b0, 3);
        set_basic();
        send_group(1'b0, 1'b0, 0);

        set_random();
        send_group(1'b0, 1'b0, 2);
        set_random();
        send_group(1'b1, 1'b0, 0);

        for (int n = 0; n < 6; n++) begin
            set_random();
            send_group(1'($urandom_range(0, 1)), 1'b1, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
